seq_pattern_detector: RTL



---
 rtl/seq_pattern_detector_if.sv | 30 +++
 rtl/seq_pattern_detector.sv | 87 ++++++++
 2 files changed

// File: rtl/seq_pattern_detector_if.sv
// Serial-stream bus for seq_pattern_detector: sample/strobe inputs and match status outputs.
// The driver of the stream uses the master modport; the detector uses slave.
interface seq_pattern_detector_if #(
   parameter int unsigned COUNT_W = 8
);
   logic               din;
   logic               din_valid;
   logic               clear;
   logic               match;
   logic [COUNT_W-1:0] match_count;
   logic               filled;

   modport master (
      output din,
      output din_valid,
      output clear,
      input  match,
      input  match_count,
      input  filled
   );

   modport slave (
      input  din,
      input  din_valid,
      input  clear,
      output match,
      output match_count,
      output filled
   );
endinterface

// File: rtl/seq_pattern_detector.sv
// Serial pattern detector: shifts valid bits into a PAT_LEN history, pulses match one cycle after
// the completing bit and keeps a saturating match count. Define SEQ_NONOVERLAP_EN for non-overlap.
module seq_pattern_detector #(
   parameter int unsigned         PAT_LEN = 4,
   parameter logic [PAT_LEN-1:0]  PATTERN = 4'b1011,
   parameter int unsigned         COUNT_W = 8
) (
   input  logic                  clock,
   input  logic                  reset,
   seq_pattern_detector_if.slave bus
);
   localparam int unsigned FillW = $clog2(PAT_LEN + 1);

   typedef enum logic {StFill, StDetect} state_e;

   state_e             r_state,    w_state_nxt;
   logic [PAT_LEN-1:0] r_hist,     w_hist_nxt;
   logic [FillW-1:0]   r_fill_cnt, w_fill_cnt_nxt;
   logic               r_match,    w_match_nxt;
   logic [COUNT_W-1:0] r_count,    w_count_nxt;
   logic [PAT_LEN-1:0] w_shifted;
   logic               w_hit;

   assign w_shifted = {r_hist[PAT_LEN-2:0], bus.din};

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state    <= StFill;
         r_hist     <= '0;
         r_fill_cnt <= '0;
         r_match    <= 1'b0;
         r_count    <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_hist     <= w_hist_nxt;
         r_fill_cnt <= w_fill_cnt_nxt;
         r_match    <= w_match_nxt;
         r_count    <= w_count_nxt;
      end
   end

   always_comb begin
      w_state_nxt    = r_state;
      w_hist_nxt     = r_hist;
      w_fill_cnt_nxt = r_fill_cnt;
      w_match_nxt    = 1'b0;
      w_count_nxt    = r_count;
      w_hit          = 1'b0;

      if (bus.clear) begin
         w_state_nxt    = StFill;
         w_hist_nxt     = '0;
         w_fill_cnt_nxt = '0;
         w_count_nxt    = '0;
      end else if (bus.din_valid) begin
         w_hist_nxt = w_shifted;
         unique case (r_state)
            StFill: begin
               w_fill_cnt_nxt = r_fill_cnt + 1'b1;
               // The bit that completes the first window is compared immediately.
               if (r_fill_cnt == FillW'(PAT_LEN - 1)) begin
                  w_state_nxt = StDetect;
                  w_hit       = (w_shifted == PATTERN);
               end
            end
            StDetect: w_hit = (w_shifted == PATTERN);
            default:  w_state_nxt = StFill;
         endcase

         if (w_hit) begin
            w_match_nxt = 1'b1;
            if (r_count != '1) begin
               w_count_nxt = r_count + 1'b1;
            end
`ifdef SEQ_NONOVERLAP_EN
            w_state_nxt    = StFill;
            w_hist_nxt     = '0;
            w_fill_cnt_nxt = '0;
`endif
         end
      end
   end

   assign bus.match       = r_match;
   assign bus.match_count = r_count;
   assign bus.filled      = (r_state == StDetect);
endmodule
